// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// BOOT_IMAGE is the program present at power-up; words past BOOT_LEN read as NOP.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int BOOT_LEN = 5;

  localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
    {OP_LDI,  4'h1, 8'h05},
    {OP_LDI,  4'h2, 8'h03},
    {OP_ADD,  4'h3, 4'h1, 4'h2},
    {OP_ST,   4'h3, 8'h00},
    {OP_HALT, 12'h000}
  };

  function automatic logic [15:0] boot_word(input int idx);
    if (idx < BOOT_LEN) begin
      return BOOT_IMAGE[idx];
    end
    return NOP;
  endfunction

endpackage

// File: rtl/program_mem_loader_fsm.sv
// Loader control: accepts the word stream from address 0, then NOP-fills the tail.
// Produces the single write port of the memory; wr_ptr is one bit wider so it never wraps.
module program_mem_loader_fsm
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'((2 ** ADDR_W) - 1);

  ld_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             err_q, err_d;
  logic             at_end;

  assign at_end = (wr_ptr_q == LAST_PTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_start_i) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid_i) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Filling the last slot ends the load; a missing last marker is an overrun.
          if (at_end) begin
            state_d = ST_DONE;
            err_d   = err_q | ~ld_last_i;
          end else if (ld_last_i) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (at_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o = (state_q == ST_LOAD);
    ld_busy_o  = (state_q != ST_IDLE);
    ld_done_o  = (state_q == ST_DONE);
    ld_err_o   = err_q;
    wr_en_o    = ((state_q == ST_LOAD) && ld_valid_i) || (state_q == ST_FILL);
    wr_addr_o  = wr_ptr_q[ADDR_W-1:0];
    wr_data_o  = (state_q == ST_LOAD) ? ld_data_i : NOP_WORD;
  end

endmodule

// File: rtl/program_mem_loadable.sv
// Instruction memory with boot image and in-system loader.
// Single-port array: the loader owns it while busy, fetch owns it otherwise.
module program_mem_loadable
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t boot_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i < BOOT_LEN) ? DATA_W'(boot_word(i)) : NOP_WORD;
    end
    return m;
  endfunction

  // Power-up contents only; reset deliberately leaves the array alone.
  mem_t mem_q = boot_init();

  logic [DATA_W-1:0] fetch_instr_q;
  logic              fetch_valid_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;

  program_mem_loader_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start_i (ld_start),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .ld_busy_o  (ld_busy),
    .ld_done_o  (ld_done),
    .ld_err_o   (ld_err),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data)
  );

  assign rd_en = fetch_req && !ld_busy;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_instr_q <= NOP_WORD;
      fetch_valid_q <= 1'b0;
    end else if (rd_en) begin
      fetch_instr_q <= mem_q[fetch_addr];
      fetch_valid_q <= 1'b1;
    end else if (fetch_req) begin
      // Request arrived during a load: drop it and present a NOP.
      fetch_instr_q <= NOP_WORD;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign fetch_instr = fetch_instr_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_program_mem_loadable.sv
// Directed-plus-random bench for program_mem_loadable against a word-array model.
module tb_program_mem_loadable;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [3:0]  fetch_addr;
  logic [15:0] fetch_instr;
  logic        fetch_valid;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [16];

  program_mem_loadable #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .NOP_WORD (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_err      (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Read back every word with back-to-back fetches and compare to the model.
  task automatic dump(input string tag);
    for (int a = 0; a < 16; a++) begin
      fetch_req  = 1'b1;
      fetch_addr = 4'(a);
      step();
      chk({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      chk({tag, "_word"}, 32'(fetch_instr), 32'(model[a]));
    end
    fetch_req = 1'b0;
    step();
    chk({tag, "_idle_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_hold"}, 32'(fetch_instr), 32'(model[15]));
    $display("dump %s: 16 words read back", tag);
  endtask

  // One complete load of n words; optional ld_valid gaps and a fetch held through it.
  task automatic stream(input int n, input bit with_last, input bit gaps, input bit hold_fetch);
    logic [3:0] faddr;
    int         j;
    bit         exp_err;
    exp_err  = (n == 16) && !with_last;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("start_busy", 32'(ld_busy), 32'd1);
    chk("start_ready", 32'(ld_ready), 32'd1);
    chk("start_err_clr", 32'(ld_err), 32'd0);
    faddr      = 4'($urandom_range(0, 15));
    fetch_req  = hold_fetch;
    fetch_addr = faddr;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 2)) begin
          ld_valid = 1'b0;
          ld_start = 1'($urandom_range(0, 1));
          step();
          chk("gap_ready", 32'(ld_ready), 32'd1);
        end
      end
      ld_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 16'($urandom);
      ld_last  = with_last && (i == n - 1);
      model[i] = ld_data;
      step();
      if (hold_fetch) begin
        chk("blk_valid", 32'(fetch_valid), 32'd0);
        chk("blk_instr", 32'(fetch_instr), 32'd0);
      end
    end
    // Keep offering a word: it must not be taken once the stream has ended.
    ld_last = 1'b0;
    ld_data = 16'($urandom);
    if (with_last) begin
      for (int a = n; a < 16; a++) model[a] = 16'h0000;
    end
    j = 0;
    while (ld_done !== 1'b1 && j < 40) begin
      step();
      j++;
      if (hold_fetch) chk("blk_fill_valid", 32'(fetch_valid), 32'd0);
    end
    chk("done_latency", 32'(j), with_last ? 32'(16 - n) : 32'd0);
    chk("done_no_ready", 32'(ld_ready), 32'd0);
    chk("done_err", 32'(ld_err), 32'(exp_err));
    ld_valid = 1'b0;
    step();
    chk("done_pulse", 32'(ld_done), 32'd0);
    chk("idle_busy", 32'(ld_busy), 32'd0);
    chk("err_sticky", 32'(ld_err), 32'(exp_err));
    if (hold_fetch) begin
      chk("drop_last_valid", 32'(fetch_valid), 32'd0);
      step();
      chk("first_fetch_valid", 32'(fetch_valid), 32'd1);
      chk("first_fetch_word", 32'(fetch_instr), 32'(model[faddr]));
      fetch_req = 1'b0;
    end
    $display("load n=%0d last=%0d gaps=%0d hold=%0d done after %0d cycles err=%0d",
             n, with_last, gaps, hold_fetch, j, ld_err);
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    model[0] = 16'h1105;
    model[1] = 16'h1203;
    model[2] = 16'h3312;
    model[3] = 16'h5300;
    model[4] = 16'hF000;
    for (int a = 5; a < 16; a++) model[a] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", 32'(fetch_instr), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    dump("boot");

    stream(3, 1'b1, 1'b0, 1'b0);
    dump("load3");

    stream(16, 1'b0, 1'b0, 1'b0);
    dump("overrun");
    stream(5, 1'b1, 1'b0, 1'b0);
    dump("load5");

    stream(7, 1'b1, 1'b0, 1'b1);
    dump("held_fetch");

    stream(6, 1'b1, 1'b1, 1'b0);
    dump("gaps");

    // Reset in the middle of a load: written words stay, the old tail survives.
    fetch_req  = 1'b1;
    fetch_addr = 4'd0;
    step();
    fetch_req = 1'b0;
    ld_start  = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 16'($urandom) | 16'h0100;
      model[i] = ld_data;
      step();
    end
    ld_data = 16'hDEAD;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_instr", 32'(fetch_instr), 32'd0);
    chk("arst_valid", 32'(fetch_valid), 32'd0);
    chk("arst_ready", 32'(ld_ready), 32'd0);
    chk("arst_busy", 32'(ld_busy), 32'd0);
    chk("arst_done", 32'(ld_done), 32'd0);
    chk("arst_err", 32'(ld_err), 32'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_idle", 32'(ld_busy), 32'd0);
    $display("reset mid-load after 2 words");
    dump("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
